// File: rtl/pixel_stream_source.sv
// Frame buffer that streams one stored frame to the conv engine on run, then waits for done.
// Defining BUBBLE_EN adds a gap_cycles input that inserts idle cycles between pixels.
module pixel_stream_source #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [PIX_W-1:0]  load_data,
  input  logic              run,
  input  logic              conv_done,
`ifdef BUBBLE_EN
  input  logic [3:0]        gap_cycles,
`endif
  output logic              start_signal,
  output logic              pixel_valid,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   pix_count
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [PIX_W-1:0]  mem [NPIX];
  logic              done_latch, done_latch_d;
  logic              start_d, valid_d, busy_d, frame_done_d;
  logic [PIX_W-1:0]  pixel_d;
  logic [CNT_W-1:0]  count_d;
  logic              emit;
  logic              in_gap;

`ifdef BUBBLE_EN
  logic [3:0] gap_len, gap_len_d, gap_cnt, gap_cnt_d;
  assign in_gap = (gap_cnt != 4'd0);
`else
  assign in_gap = 1'b0;
`endif

  // Frame storage: writable only while idle; never cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && load_en && (state == S_IDLE) && (32'(load_addr) < NPIX))
      mem[load_addr] <= load_data;
  end

  // Next-state and next-output logic; pix_count doubles as the read address.
  always_comb begin
    state_d      = state;
    done_latch_d = done_latch;
    start_d      = 1'b0;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;
    pixel_d      = pixel_out;
    count_d      = pix_count;
    emit         = 1'b0;
`ifdef BUBBLE_EN
    gap_len_d    = gap_len;
    gap_cnt_d    = gap_cnt;
`endif
    unique case (state)
      S_IDLE: begin
        done_latch_d = 1'b0;
        if (run) begin
          state_d = S_START;
          start_d = 1'b1;
          count_d = '0;
`ifdef BUBBLE_EN
          gap_len_d = gap_cycles;
          gap_cnt_d = 4'd0;
`endif
        end
      end
      S_START: begin
        done_latch_d = done_latch | conv_done;
        emit         = 1'b1;
        state_d      = S_STREAM;
      end
      S_STREAM: begin
        done_latch_d = done_latch | conv_done;
        if (in_gap) begin
`ifdef BUBBLE_EN
          gap_cnt_d = gap_cnt - 4'd1;
`endif
        end else if (pix_count == CNT_W'(NPIX)) begin
          state_d = S_WAIT_DONE;
        end else begin
          emit = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (conv_done || done_latch) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        done_latch_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      valid_d = 1'b1;
      pixel_d = mem[pix_count[ADDR_W-1:0]];
      count_d = pix_count + CNT_W'(1);
`ifdef BUBBLE_EN
      // No bubble after the final pixel.
      gap_cnt_d = (count_d == CNT_W'(NPIX)) ? 4'd0 : gap_len;
`endif
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      done_latch   <= 1'b0;
      start_signal <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel_out    <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      pix_count    <= '0;
`ifdef BUBBLE_EN
      gap_len      <= 4'd0;
      gap_cnt      <= 4'd0;
`endif
    end else begin
      state        <= state_d;
      done_latch   <= done_latch_d;
      start_signal <= start_d;
      pixel_valid  <= valid_d;
      pixel_out    <= pixel_d;
      busy         <= busy_d;
      frame_done   <= frame_done_d;
      pix_count    <= count_d;
`ifdef BUBBLE_EN
      gap_len      <= gap_len_d;
      gap_cnt      <= gap_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Self-checking bench for pixel_stream_source: timing-based frame model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_pixel_stream_source;

  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 8;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int P = IMG_W * IMG_H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, load_en, run, conv_done;
  logic [ADDR_W-1:0] load_addr;
  logic [PIX_W-1:0]  load_data;
`ifdef BUBBLE_EN
  logic [3:0]        gap_cycles;
`endif
  logic              start_signal, pixel_valid, busy, frame_done;
  logic [PIX_W-1:0]  pixel_out;
  logic [ADDR_W:0]   pix_count;

  pixel_stream_source #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .run(run), .conv_done(conv_done),
`ifdef BUBBLE_EN
    .gap_cycles(gap_cycles),
`endif
    .start_signal(start_signal), .pixel_valid(pixel_valid), .pixel_out(pixel_out),
    .busy(busy), .frame_done(frame_done), .pix_count(pix_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is described by time t since run acceptance (t=1 is the start cycle).
  logic [PIX_W-1:0] mmem [P];
  bit   m_init = 0, m_act = 0, m_seen = 0;
  int   m_t = 0, m_g = 0, m_fd = 0, m_cnt = 0, tw;
  logic [PIX_W-1:0] m_last = '0;

  int   cyc = 0, n_start = 0, n_valid = 0, n_fd = 0, st_cyc = 0, fv_cyc = 0, lv_cyc = 0;
  bit   want_fv = 0;
  logic [PIX_W-1:0] seen_pix [P];

  always @(negedge clk) begin
    bit e_valid;
    int k;
    cyc++;
    if (m_init) begin
      e_valid = 0;
      k = 0;
      if (m_act && m_t >= 2 && ((m_t - 2) % (m_g + 1)) == 0 && ((m_t - 2) / (m_g + 1)) < P) begin
        e_valid = 1;
        k = (m_t - 2) / (m_g + 1);
        m_last = mmem[k];
      end
      if (m_act) begin
        m_cnt = (m_t < 2) ? 0 : ((m_t - 2) / (m_g + 1) + 1);
        if (m_cnt > P) m_cnt = P;
      end
      chk("start_signal", 32'(start_signal), 32'(m_act && m_t == 1));
      chk("pixel_valid", 32'(pixel_valid), 32'(e_valid));
      chk("pixel_out", 32'(pixel_out), 32'(m_last));
      chk("busy", 32'(busy), 32'(m_act));
      chk("frame_done", 32'(frame_done), 32'(m_act && m_t == m_fd));
      chk("pix_count", 32'(pix_count), 32'(m_cnt));
      if (start_signal === 1'b1) begin n_start++; st_cyc = cyc; want_fv = 1; end
      if (pixel_valid === 1'b1) begin
        n_valid++;
        lv_cyc = cyc;
        if (want_fv) begin fv_cyc = cyc; want_fv = 0; end
        if (e_valid) seen_pix[k] = pixel_out;
      end
      if (frame_done === 1'b1) n_fd++;
    end
    // Predict the next cycle from the inputs the coming edge will sample.
    if (!rst) begin
      m_init = 1; m_act = 0; m_last = '0; m_cnt = 0;
    end else if (m_init) begin
      if (m_act) begin
        tw = 2 + (P - 1) * (m_g + 1) + 1;
        if (conv_done) m_seen = 1;
        if (m_seen && m_t >= tw && m_fd == 0) m_fd = m_t + 1;
        if (m_t == m_fd) m_act = 0;
        else m_t++;
      end else begin
        if (load_en) mmem[load_addr] = load_data;
        if (run) begin
          m_act = 1; m_t = 1; m_seen = 0; m_fd = 0; m_g = 0;
`ifdef BUBBLE_EN
          m_g = int'(gap_cycles);
`endif
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < P; i++) begin
      load_en = 1'b1; load_addr = ADDR_W'(i); load_data = PIX_W'(i);
      step(1);
    end
    load_en = 1'b0;
  endtask

  // Returns in the start_signal cycle.
  task automatic start_run();
    run = 1'b1;
    step(1);
    run = 1'b0;
  endtask

  int s0, v0, f0;

  initial begin
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; run = 1'b0; conv_done = 1'b0;
`ifdef BUBBLE_EN
    gap_cycles = 4'd0;
`endif
    step(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(pixel_valid), 32'd0);
    chk("rst_start", 32'(start_signal), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_pix", 32'(pixel_out), 32'd0);
    chk("rst_cnt", 32'(pix_count), 32'd0);
    rst = 1'b1;
    load_ramp();

    // conv_done never arrives: stays in WAIT_DONE
    s0 = n_start; v0 = n_valid;
    start_run();
    chk("first_start", 32'(start_signal), 32'd1);
    step(150);
    chk("hang_busy", 32'(busy), 32'd1);
    chk("hang_valid", 32'(pixel_valid), 32'd0);
    chk("hang_cnt", 32'(pix_count), 32'd64);
    chk("hang_nstart", 32'(n_start - s0), 32'd1);
    chk("hang_nvalid", 32'(n_valid - v0), 32'd64);
    chk("hang_span", 32'(lv_cyc - fv_cyc), 32'd63);
    chk("hang_lat", 32'(fv_cyc - st_cyc), 32'd1);
    rst = 1'b0; step(1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cnt", 32'(pix_count), 32'd0);
    rst = 1'b1;

    // nominal frame, conv_done 10 cycles after last pixel
    f0 = n_fd;
    start_run();
    step(74); conv_done = 1'b1; step(1); conv_done = 1'b0;
    chk("nom_fd", 32'(frame_done), 32'd1);
    chk("nom_cnt", 32'(pix_count), 32'd64);
    chk("nom_last", 32'(pixel_out), 32'd63);
    step(1);
    chk("nom_fd_off", 32'(frame_done), 32'd0);
    chk("nom_idle", 32'(busy), 32'd0);
    chk("nom_nfd", 32'(n_fd - f0), 32'd1);

    // write and rerun while busy are ignored
    s0 = n_start;
    start_run();
    step(5);
    load_en = 1'b1; load_addr = 6'd5; load_data = 8'hFF; run = 1'b1;
    step(1);
    load_en = 1'b0; run = 1'b0;
    step(60); conv_done = 1'b1; step(1); conv_done = 1'b0;
    chk("ign_fd", 32'(frame_done), 32'd1);
    chk("ign_nstart", 32'(n_start - s0), 32'd1);
    step(1);

    // early done during pixel 20
    start_run();
    step(21);
    chk("early_pix20", 32'(pixel_out), 32'd20);
    conv_done = 1'b1; step(1); conv_done = 1'b0;
    step(44);
    chk("early_fd", 32'(frame_done), 32'd1);
    step(1);
    chk("early_mem5", 32'(seen_pix[5]), 32'd5);

    // reset mid-stream at pixel 30
    f0 = n_fd;
    start_run();
    step(31);
    chk("mid_pix30", 32'(pixel_out), 32'd30);
    rst = 1'b0; step(1);
    chk("mid_valid", 32'(pixel_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step(80);
    chk("mid_nofd", 32'(n_fd - f0), 32'd0);
    conv_done = 1'b1;
    start_run();
    step(70);
    conv_done = 1'b0;
    chk("rerun_nfd", 32'(n_fd - f0), 32'd1);
    for (int i = 0; i < P; i++) chk("rerun_pix", 32'(seen_pix[i]), 32'(i));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      run       = ($urandom % 12) == 0;
      load_en   = ($urandom % 4) == 0;
      load_addr = ADDR_W'($urandom);
      load_data = PIX_W'($urandom);
      conv_done = ($urandom % 25) == 0;
      rst       = ($urandom % 700) != 0;
`ifdef BUBBLE_EN
      gap_cycles = 4'($urandom % 4);
`endif
      step(1);
    end
    run = 1'b0; load_en = 1'b0; conv_done = 1'b0;
    rst = 1'b0; step(1); rst = 1'b1;

`ifdef BUBBLE_EN
    load_ramp();
    gap_cycles = 4'd2;
    v0 = n_valid;
    start_run();
    gap_cycles = 4'd0;
    step(200);
    chk("gap_nvalid", 32'(n_valid - v0), 32'd64);
    chk("gap_span", 32'(lv_cyc - fv_cyc), 32'd189);
    for (int i = 0; i < P; i += 7) chk("gap_pix", 32'(seen_pix[i]), 32'(i));
    conv_done = 1'b1; step(1); conv_done = 1'b0;
    chk("gap_fd", 32'(frame_done), 32'd1);
    step(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
